// File: rtl/dff_arb_pkg.sv
// Shared types for the round-robin shared-register arbiter: FSM encoding and
// the rotating-priority pick used to choose the next owner.
package dff_arb_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } pick_t;

  // First set request bit searching ptr, ptr+1, ... modulo n (n <= MAX_REQ).
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [2:0]         ptr,
                                    input int unsigned        n);
    pick_t       p;
    int unsigned i;
    p = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      i = (32'(ptr) + k) % n;
      if (k < n && !p.valid && req[i[2:0]]) begin
        p.valid = 1'b1;
        p.idx   = i[2:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/dff_reg_arbiter_if.sv
// Requester-side bus of the shared-register arbiter: requests/data in,
// grant status and the shared register contents out.
interface dff_reg_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [OW-1:0]         owner;
  logic                  busy;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      qbar;

  modport master (output req, wdata, input gnt, owner, busy, q, qbar);
  modport slave  (input req, wdata, output gnt, owner, busy, q, qbar);
endinterface

// File: rtl/df_reg_bank.sv
// WIDTH D flip-flops with load enable and synchronous clear; qbar is kept as
// its own flop so both rails change on the same edge.
module df_reg_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);
  logic [WIDTH-1:0] q_d, q_q, qbar_d, qbar_q;

  always_comb begin
    q_d    = q_q;
    qbar_d = qbar_q;
    if (en) begin
      q_d    = d;
      qbar_d = ~d;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      q_q    <= '0;
      qbar_q <= '1;
    end else begin
      q_q    <= q_d;
      qbar_q <= qbar_d;
    end
  end

  assign q    = q_q;
  assign qbar = qbar_q;
endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter granting one requester at a time write access to a shared
// register bank, with tenures capped at HOLD_MAX writes.
module dff_reg_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 3
) (
  input logic               clk,
  input logic               clear,
  dff_reg_arbiter_if.slave  bus
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e           state_d, state_q;
  logic [NREQ-1:0]  gnt_d, gnt_q;
  logic [OW-1:0]    owner_d, owner_q;
  logic [OW-1:0]    rr_ptr_d, rr_ptr_q;
  logic [3:0]       hold_cnt_d, hold_cnt_q;
  logic [MAX_REQ-1:0] req_pad;
  pick_t            pick;
  logic             bank_en;
  logic [WIDTH-1:0] bank_d;

  always_comb begin
    req_pad             = '0;
    req_pad[NREQ-1:0]   = bus.req;
    pick                = rr_pick(req_pad, 3'(rr_ptr_q), NREQ);
    bank_d              = bus.wdata[owner_q*WIDTH +: WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    bank_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick.valid) begin
          state_d                    = ST_GRANT;
          gnt_d                      = '0;
          gnt_d[pick.idx[OW-1:0]]    = 1'b1;
          owner_d                    = pick.idx[OW-1:0];
          hold_cnt_d                 = 4'd1;
        end
      end
      ST_GRANT: begin
        if (bus.req[owner_q]) begin
          bank_en = 1'b1;
          if (hold_cnt_q == 4'(HOLD_MAX)) begin
            state_d = ST_RELEASE;
            gnt_d   = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 4'd1;
          end
        end else begin
          state_d = ST_RELEASE;
          gnt_d   = '0;
        end
      end
      ST_RELEASE: begin
        // Next search starts just past the owner that was just released.
        rr_ptr_d = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Bank clear wins over a write on the same edge.
  df_reg_bank #(.WIDTH(WIDTH)) u_bank (
    .clk   (clk),
    .clear (clear),
    .en    (bank_en),
    .d     (bank_d),
    .q     (bus.q),
    .qbar  (bus.qbar)
  );

  assign bus.gnt   = gnt_q;
  assign bus.owner = owner_q;
  assign bus.busy  = (state_q == ST_GRANT);
endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Randomized and directed bench for dff_reg_arbiter against a tenure-level model.
module tb_dff_reg_arbiter;
  localparam int NREQ = 4, WIDTH = 8, HOLD_MAX = 3;
  localparam int VW = NREQ + 2 + 1 + 2 * WIDTH;

  logic clk = 1'b0;
  logic clear = 1'b1;
  always #5 clk = ~clk;

  dff_reg_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  dff_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus.slave)
  );

  int checks = 0, failures = 0;

  // Model: phase 0 idle, 1 granted, 2 released; writes counted per tenure.
  int m_phase = 0, m_owner = 0, m_ptr = 0, m_writes = 0;
  logic [WIDTH-1:0] m_q = '0;

  task automatic tick();
    if (clear) begin
      m_phase = 0; m_owner = 0; m_ptr = 0; m_writes = 0; m_q = '0;
    end else if (m_phase == 0) begin
      for (int k = NREQ - 1; k >= 0; k--)
        if (bus.req[(m_ptr + k) % NREQ]) begin
          m_owner = (m_ptr + k) % NREQ;
          m_phase = 1;
        end
      m_writes = 0;
    end else if (m_phase == 1) begin
      if (bus.req[m_owner]) begin
        m_q = bus.wdata[m_owner*WIDTH +: WIDTH];
        m_writes++;
        if (m_writes == HOLD_MAX) m_phase = 2;
      end else m_phase = 2;
    end else begin
      m_ptr   = (m_owner + 1) % NREQ;
      m_phase = 0;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [NREQ-1:0] g;
    logic [1:0]      o;
    g = (m_phase == 1) ? NREQ'(1 << m_owner) : '0;
    o = m_owner[1:0];
    return {g, o, (m_phase == 1), m_q, ~m_q};
  endfunction

  function automatic logic [VW-1:0] act_vec();
    return {bus.gnt, bus.owner, bus.busy, bus.q, bus.qbar};
  endfunction

  task automatic test_reset();
    clear = 1'b1; bus.req = '0; bus.wdata = '0;
    tick(); tick();
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt act=%b exp=0000", bus.gnt); end
    checks++; if (bus.q !== 8'h00) begin failures++; $display("FAIL reset_q act=%h exp=00", bus.q); end
    checks++; if (bus.qbar !== 8'hFF) begin failures++; $display("FAIL reset_qbar act=%h exp=ff", bus.qbar); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy act=%b exp=0", bus.busy); end
    checks++; if (bus.owner !== 2'd0) begin failures++; $display("FAIL reset_owner act=%0d exp=0", bus.owner); end
    clear = 1'b0;
  endtask

  task automatic test_single();
    bus.req = 4'b0010; bus.wdata = '0; bus.wdata[15:8] = 8'hA5;
    tick();
    checks++; if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL single_gnt act=%b exp=0010", bus.gnt); end
    tick();
    checks++; if (bus.q !== 8'hA5 || bus.qbar !== 8'h5A) begin failures++; $display("FAIL single_q act=%h/%h exp=a5/5a", bus.q, bus.qbar); end
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (act_vec() !== exp_vec()) begin failures++; $display("FAIL single_cyc%0d act=%h exp=%h", c, act_vec(), exp_vec()); end
    end
    bus.req = '0;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_round_robin();
    int n = 0;
    logic pb = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    bus.req = 4'b1111;
    for (int i = 0; i < NREQ; i++) bus.wdata[i*WIDTH +: WIDTH] = 8'h10 + 8'(i);
    for (int c = 0; c < 25; c++) begin
      tick();
      checks++; if (act_vec() !== exp_vec()) begin failures++; $display("FAIL rr_cyc%0d act=%h exp=%h", c, act_vec(), exp_vec()); end
      if (bus.busy && !pb) begin
        checks++; if (int'(bus.owner) != n % NREQ) begin failures++; $display("FAIL rr_owner%0d act=%0d exp=%0d", n, bus.owner, n % NREQ); end
        n++;
      end
      if (!bus.busy && pb) begin
        checks++; if (bus.q !== 8'h10 + 8'(bus.owner)) begin failures++; $display("FAIL rr_tenure_q act=%h exp=%h", bus.q, 8'h10 + 8'(bus.owner)); end
      end
      pb = bus.busy;
    end
    checks++; if (n != 5) begin failures++; $display("FAIL rr_tenures act=%0d exp=5", n); end
    bus.req = '0;
  endtask

  task automatic test_early_drop();
    clear = 1'b1; tick(); clear = 1'b0;
    bus.req = 4'b0100; bus.wdata[23:16] = 8'hC3;
    tick(); tick();
    bus.req = 4'b0011;
    tick();
    checks++; if (bus.gnt !== 4'b0000 || bus.q !== 8'hC3) begin failures++; $display("FAIL drop_release act=%b/%h exp=0000/c3", bus.gnt, bus.q); end
    tick(); tick();
    checks++; if (bus.gnt !== 4'b0001 || bus.owner !== 2'd0) begin failures++; $display("FAIL drop_next act=%b/%0d exp=0001/0", bus.gnt, bus.owner); end
    checks++; if (act_vec() !== exp_vec()) begin failures++; $display("FAIL drop_model act=%h exp=%h", act_vec(), exp_vec()); end
    bus.req = '0;
  endtask

  task automatic test_reset_mid();
    clear = 1'b1; tick(); clear = 1'b0;
    bus.req = 4'b0010; bus.wdata[15:8] = 8'h77;
    tick(); tick();
    clear = 1'b1;
    tick();
    checks++; if (bus.gnt !== 4'b0000 || bus.q !== 8'h00 || bus.qbar !== 8'hFF) begin failures++; $display("FAIL midclr act=%b/%h/%h exp=0000/00/ff", bus.gnt, bus.q, bus.qbar); end
    clear = 1'b0; bus.req = 4'b1111;
    tick();
    checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL midclr_regrant act=%b exp=0001", bus.gnt); end
    bus.req = '0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) != 0) bus.req = NREQ'($urandom);
      bus.wdata = ($urandom << 16) ^ $urandom;
      clear = ($urandom_range(0, 39) == 0);
      tick();
      checks++; if (act_vec() !== exp_vec()) begin failures++; $display("FAIL rand_cyc%0d act=%h exp=%h", c, act_vec(), exp_vec()); end
      checks++; if (!$onehot0(bus.gnt) || bus.qbar !== ~bus.q || bus.busy !== (|bus.gnt)) begin
        failures++; $display("FAIL rand_inv%0d gnt=%b q=%h qbar=%h busy=%b", c, bus.gnt, bus.q, bus.qbar, bus.busy);
      end
    end
    clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_early_drop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
